// File: rtl/nios_system_sysid_regs.sv
//==============================================================================
// Module      : nios_system_sysid_regs
// Description : Avalon-MM system-ID and uptime register block. Returns a fixed
//               ID word and build timestamp, and provides a prescaled free-
//               running uptime counter with a coherent LO/HI snapshot, a
//               scratch register and a control register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module nios_system_sysid_regs #(
    parameter logic [31:0] ID_VALUE       = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP      = 32'h0000_0000,
    parameter int          CNT_WIDTH      = 48,
    parameter logic [31:0] PRESCALE_RESET = 32'd0,
    parameter logic [31:0] SCRATCH_RESET  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    // Register map
    localparam logic [2:0] c_addr_id       = 3'd0;
    localparam logic [2:0] c_addr_ts       = 3'd1;
    localparam logic [2:0] c_addr_lo       = 3'd2;
    localparam logic [2:0] c_addr_hi       = 3'd3;
    localparam logic [2:0] c_addr_scratch  = 3'd4;
    localparam logic [2:0] c_addr_control  = 3'd5;
    localparam logic [2:0] c_addr_prescale = 3'd6;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [31:0]          r_pc;
    logic [31:0]          r_shadow;
    logic                 r_en;
    logic [31:0]          r_scratch;
    logic [31:0]          r_prescale;

    logic                 w_wr_scratch;
    logic                 w_wr_control;
    logic                 w_wr_prescale;
    logic                 w_clr;
    logic                 w_tick;
    logic                 w_rd_lo;
    logic [31:0]          w_cnt_hi;
    logic [31:0]          w_scratch_next;
    logic [31:0]          w_prescale_next;
    logic [31:0]          w_rdata;

    // CONTROL only has bits in byte lane 0, so lane 0 gates the whole write
    assign w_wr_scratch  = write && (address == c_addr_scratch);
    assign w_wr_control  = write && (address == c_addr_control) && byteenable[0];
    assign w_wr_prescale = write && (address == c_addr_prescale);
    assign w_clr         = w_wr_control && writedata[1];
    assign w_tick        = (r_pc == r_prescale);
    assign w_rd_lo       = read && (address == c_addr_lo);

    // Upper counter bits zero-extended to a full word for the shadow
    always_comb begin
        w_cnt_hi                   = '0;
        w_cnt_hi[CNT_WIDTH-33:0]   = r_cnt[CNT_WIDTH-1:32];
    end

    // Byte-lane merge for the two byte-writable registers
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_scratch_next[8*i +: 8]  = byteenable[i] ? writedata[8*i +: 8]
                                                         : r_scratch[8*i +: 8];
        assign w_prescale_next[8*i +: 8] = byteenable[i] ? writedata[8*i +: 8]
                                                         : r_prescale[8*i +: 8];
    end

    // Read mux; reflects register state before any same-cycle write
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (address)
            c_addr_id:       w_rdata = ID_VALUE;
            c_addr_ts:       w_rdata = TIMESTAMP;
            c_addr_lo:       w_rdata = r_cnt[31:0];
            c_addr_hi:       w_rdata = r_shadow;
            c_addr_scratch:  w_rdata = r_scratch;
            c_addr_control:  w_rdata = {31'b0, r_en};
            c_addr_prescale: w_rdata = r_prescale;
            default:         w_rdata = 32'h0000_0000;
        endcase
    end

    // Uptime counter and prescaler: CLR beats a PRESCALE write, which beats a tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_pc  <= 32'd0;
        end else if (w_clr) begin
            r_cnt <= '0;
            r_pc  <= 32'd0;
        end else if (w_wr_prescale) begin
            r_pc  <= 32'd0;
        end else if (r_en) begin
            if (w_tick) begin
                r_pc  <= 32'd0;
                r_cnt <= r_cnt + c_cnt_one;
            end else begin
                r_pc  <= r_pc + 32'd1;
            end
        end
    end

    // Shadow captures the upper counter bits from the same pre-edge value as LO
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow <= 32'd0;
        end else if (w_clr) begin
            r_shadow <= 32'd0;
        end else if (w_rd_lo) begin
            r_shadow <= w_cnt_hi;
        end
    end

    // Software-writable configuration registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_en       <= 1'b1;
            r_scratch  <= SCRATCH_RESET;
            r_prescale <= PRESCALE_RESET;
        end else begin
            if (w_wr_control) begin
                r_en <= writedata[0];
            end
            if (w_wr_scratch) begin
                r_scratch <= w_scratch_next;
            end
            if (w_wr_prescale) begin
                r_prescale <= w_prescale_next;
            end
        end
    end

    // Registered read response; data holds between reads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata      <= 32'd0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= w_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nios_system_sysid_regs.sv
//==============================================================================
// Module      : tb_nios_system_sysid_regs
// Description : Self-checking bench for nios_system_sysid_regs. Reads push
//               their expected data into a queue; a monitor pops and compares
//               whenever readdatavalid is due.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_nios_system_sysid_regs;

    localparam logic [31:0] c_id       = 32'hCAFE0001;
    localparam logic [31:0] c_ts       = 32'd1476641584;
    localparam int          c_cw       = 33;
    localparam logic [31:0] c_scr_rst  = 32'h5A5A_0F0F;
    localparam logic [31:0] c_pre_rst  = 32'd0;

    logic        clock;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic        rd_at_edge;
    logic        exp_v;
    logic [31:0] mon_e;
    string       mon_t;

    nios_system_sysid_regs #(
        .ID_VALUE       (c_id),
        .TIMESTAMP      (c_ts),
        .CNT_WIDTH      (c_cw),
        .PRESCALE_RESET (c_pre_rst),
        .SCRATCH_RESET  (c_scr_rst)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle, entered and left on a falling edge
    task automatic bus(input logic rd, input logic wr, input logic [2:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] exp, input string tag);
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = wd;
        byteenable = be;
        if (rd) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, input logic [31:0] exp, input string tag);
        bus(1'b1, 1'b0, a, 32'h0, 4'h0, exp, tag);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        bus(1'b0, 1'b1, a, d, be, 32'h0, "");
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Response monitor: a read accepted at an edge must be answered right after it
    always @(posedge clock) begin
        rd_at_edge = read;
        #1;
        exp_v = rd_at_edge && !reset;
        if (exp_v || readdatavalid) begin
            check("rdv", {31'b0, readdatavalid}, {31'b0, exp_v});
        end
        if (exp_v) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                if (readdatavalid) begin
                    check(mon_t, readdata, mon_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = 3'd0;
        writedata  = 32'h0;
        byteenable = 4'h0;

        // Reset state
        idle(2);
        check("rst_rdv", {31'b0, readdatavalid}, 32'd0);
        check("rst_rdata", readdata, 32'd0);

        // Free-running count with PRESCALE=0: read issued on the 11th edge sees 10
        reset = 1'b0;
        idle(10);
        rd_reg(3'd2, 32'd10, "lo_after_10");
        rd_reg(3'd3, 32'd0,  "hi_after_10");

        // Constant words and reserved address, back to back
        rd_reg(3'd0, c_id, "id");
        rd_reg(3'd1, c_ts, "timestamp");
        rd_reg(3'd7, 32'd0, "reserved");
        wr_reg(3'd0, 32'h1111_2222, 4'hF);
        rd_reg(3'd0, c_id, "id_after_wr");
        wr_reg(3'd7, 32'hFFFF_FFFF, 4'hF);
        rd_reg(3'd7, 32'd0, "rsv_after_wr");

        // Reset values of writable registers
        rd_reg(3'd5, 32'd1, "ctrl_rst");
        rd_reg(3'd6, c_pre_rst, "pre_rst");
        rd_reg(3'd4, c_scr_rst, "scr_rst");

        // LO/HI coherence across the 32-bit carry, PRESCALE=1
        wr_reg(3'd5, 32'h0, 4'h1);
        wr_reg(3'd6, 32'd1, 4'hF);
        force dut.r_cnt = 33'h0_FFFF_FFFF;
        #1;
        release dut.r_cnt;
        rd_reg(3'd2, 32'hFFFF_FFFF, "lo_prewrap");
        wr_reg(3'd5, 32'h1, 4'h1);
        idle(2);
        rd_reg(3'd3, 32'd0, "hi_after_carry");
        rd_reg(3'd2, 32'd0, "lo_postwrap");
        rd_reg(3'd3, 32'd1, "hi_postwrap");

        // Full-width wrap back to zero, PRESCALE=0
        wr_reg(3'd5, 32'h0, 4'h1);
        wr_reg(3'd6, 32'd0, 4'hF);
        force dut.r_cnt = 33'h1_FFFF_FFFF;
        #1;
        release dut.r_cnt;
        wr_reg(3'd5, 32'h1, 4'h1);
        idle(1);
        rd_reg(3'd2, 32'd0, "lo_fullwrap");
        rd_reg(3'd3, 32'd0, "hi_fullwrap");

        // PRESCALE=3 then CLR with EN kept: read k cycles after the CLR sees (k-1)/4
        wr_reg(3'd6, 32'd3, 4'hF);
        wr_reg(3'd5, 32'h3, 4'h1);
        for (int k = 1; k <= 9; k++) begin
            rd_reg(3'd2, 32'((k - 1) / 4), $sformatf("pre3_k%0d", k));
        end
        wr_reg(3'd5, 32'h0, 4'h1);
        idle(100);
        rd_reg(3'd2, 32'd2, "lo_frozen");
        rd_reg(3'd3, 32'd0, "hi_frozen");
        rd_reg(3'd5, 32'd0, "ctrl_en_off");
        wr_reg(3'd5, 32'h1, 4'hE);
        rd_reg(3'd5, 32'd0, "ctrl_be_ignored");

        // SCRATCH byte lanes and read-before-write in one cycle
        wr_reg(3'd4, 32'h1234_5678, 4'hF);
        wr_reg(3'd4, 32'hAAAA_AAAA, 4'b0101);
        rd_reg(3'd4, 32'h12AA_56AA, "scr_bytes");
        bus(1'b1, 1'b1, 3'd4, 32'hDEAD_BEEF, 4'hF, 32'h12AA_56AA, "scr_rw_old");
        rd_reg(3'd4, 32'hDEAD_BEEF, "scr_rw_new");

        // Reset right after a read strobe drops the response
        read    = 1'b1;
        address = 3'd4;
        @(posedge clock);
        reset = 1'b1;
        @(negedge clock);
        read = 1'b0;
        check("rstmid_rdv", {31'b0, readdatavalid}, 32'd0);
        check("rstmid_rdata", readdata, 32'd0);
        idle(2);
        check("rstmid_rdv2", {31'b0, readdatavalid}, 32'd0);
        reset = 1'b0;
        rd_reg(3'd4, c_scr_rst, "scr_after_rst");
        rd_reg(3'd6, c_pre_rst, "pre_after_rst");
        rd_reg(3'd5, 32'd1, "ctrl_after_rst");

        idle(3);
        check("sb_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
